sum_arbiter: RTL

Shares one external W-bit adder between NREQ requesters, such as several multipliers or counters that each need occasional add cycles. Each cycle it grants the adder to at most one requester, using round-robin priority. A requester may lock the adder for consecutive cycles, for example an alternating SUM/INC sequence, and a burst limit bounds that lock. Grant, adder operands and result are all same-cycle combinational, so a requester captures the sum at the clock edge that ends its granted cycle.

---
 rtl/sum_arbiter_if.sv | 26 ++
 rtl/sum_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/sum_arbiter_if.sv
// rtl/sum_arbiter_if.sv - requester/adder bundle shared between the arbiter and its clients
interface sum_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      sum_in_a;
  logic [W-1:0]      sum_in_b;
  logic [W-1:0]      sum_out;
  logic [W-1:0]      res;
  logic              busy;

  modport master (
    output req, lock, op_a, op_b, sum_out,
    input  gnt, sum_in_a, sum_in_b, res, busy
  );

  modport slave (
    input  req, lock, op_a, op_b, sum_out,
    output gnt, sum_in_a, sum_in_b, res, busy
  );
endinterface

// File: rtl/sum_arbiter.sv
// rtl/sum_arbiter.sv - round-robin arbiter sharing one external adder, with bounded lock bursts
module sum_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 16,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  sum_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      bcnt_q, bcnt_d;

  logic [PW-1:0]   g_idx;
  logic [PW-1:0]   cand;
  logic            g_any;
  logic            from_lock;

  // Grant selection: a live lock under its burst limit wins, else round-robin after ptr.
  always_comb begin
    g_idx     = '0;
    cand      = '0;
    g_any     = 1'b0;
    from_lock = 1'b0;
    if (state_q == LOCKED && bus.req[owner_q] && bcnt_q < BURST_LIM) begin
      g_idx     = owner_q;
      g_any     = 1'b1;
      from_lock = 1'b1;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        cand = PW'((int'(ptr_q) + i) % NREQ);
        if (!g_any && bus.req[cand]) begin
          g_any = 1'b1;
          g_idx = cand;
        end
      end
    end
  end

  always_comb begin
    bus.gnt      = '0;
    bus.sum_in_a = '0;
    bus.sum_in_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g_any && g_idx == PW'(k)) begin
        bus.gnt[k]   = 1'b1;
        bus.sum_in_a = bus.op_a[k*W +: W];
        bus.sum_in_b = bus.op_b[k*W +: W];
      end
    end
  end

  assign bus.res  = bus.sum_out;
  assign bus.busy = g_any;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    if (g_any) begin
      ptr_d = g_idx;
      if (bus.lock[g_idx]) begin
        state_d = LOCKED;
        owner_d = g_idx;
        // Only a continuation of the current run counts up; any fresh grant starts a new run.
        bcnt_d  = from_lock ? bcnt_q + 4'd1 : 4'd1;
      end else begin
        state_d = UNLOCKED;
        bcnt_d  = '0;
      end
    end else begin
      state_d = UNLOCKED;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ptr_q   <= PW'(NREQ - 1);
      owner_q <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
    end
  end
endmodule
